axis_rr_mux: RTL and testbench



---
 rtl/axis_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/axis_rr_mux.sv | 96 +++++++++
 tb/tb_axis_rr_mux.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream arbitration types: default data width, arbiter FSM states
// and the round-robin pointer wrap helper.
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority search: first set req after last_grant, wrapping.
// Zero latency, no state; reusable by any arbiter that keeps its own last_grant.
module rr_pick
  import axis_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDW     = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     sel,
  output logic               any
);

  always_comb begin
    int idx;
    sel = '0;
    any = 1'b0;
    idx = rr_next(int'(last_grant), N_PORTS);
    // last_grant itself is visited last, so it only wins when nobody else asks
    for (int k = 0; k < N_PORTS; k++) begin
      if (!any && req[IDW'(idx)]) begin
        sel = IDW'(idx);
        any = 1'b1;
      end
      idx = rr_next(idx, N_PORTS);
    end
  end

endmodule

// File: rtl/axis_rr_mux.sv
// Packet-level round-robin mux of N_PORTS AXI-Stream inputs onto one output.
// Grant visible 1 cycle after tvalid, data path combinational; m_axis_tready stalls only the granted port.
module axis_rr_mux
  import axis_pkg::*;
#(
  parameter  int N_PORTS    = 4,
  parameter  int DATA_WIDTH = AXIS_DATA_WIDTH,
  localparam int IDW        = $clog2(N_PORTS)
) (
  input  logic                          axis_clk,
  input  logic                          axis_reset,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  output logic [N_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id
);

  arb_state_e            state_q, state_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [IDW-1:0]        pick_sel;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] port_dat [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign port_dat[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IDW     (IDW)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .sel        (pick_sel),
    .any        (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        // Arbitrate only; no beat moves in this cycle, which gives the inter-packet bubble
        if (pick_any) begin
          grant_id_d    = pick_sel;
          grant_valid_d = 1'b1;
          state_d       = PKT;
        end
      end
      PKT: begin
        m_axis_tdata              = port_dat[grant_id_q];
        m_axis_tvalid             = s_axis_tvalid[grant_id_q];
        m_axis_tlast              = s_axis_tlast[grant_id_q];
        s_axis_tready[grant_id_q] = m_axis_tready;
        if (s_axis_tvalid[grant_id_q] && m_axis_tready && s_axis_tlast[grant_id_q]) begin
          last_grant_d  = grant_id_q;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= IDW'(N_PORTS - 1);
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_axis_rr_mux.sv
// Directed and randomised checks of the packet round-robin AXI-Stream mux.
module tb_axis_rr_mux;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic              axis_clk = 1'b0;
  logic              axis_reset;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tlast;
  logic [N-1:0]      s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

  always #5 axis_clk = ~axis_clk;

  axis_rr_mux #(
    .N_PORTS    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .axis_clk      (axis_clk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Source/scoreboard state for the automatic packet generator
  int fixed_len, rdy_pct, cyc, open_port;
  bit src_rand;
  int src_goal [N];
  int src_pkt  [N];
  int src_beat [N];
  int exp_pkt  [N];
  int exp_beat [N];
  int first_port [$];
  int first_cyc  [$];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge axis_clk);
  endtask

  task automatic set_port(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    s_axis_tvalid[p]         = v;
    s_axis_tdata[p*DW +: DW] = d;
    s_axis_tlast[p]          = l;
  endtask

  function automatic logic [DW-1:0] mk(input int p, input int k, input int b);
    return {4'hC, 4'(p), 8'(k), 8'(b), 8'h5A};
  endfunction

  function automatic int plen(input int p, input int k);
    return (fixed_len > 0) ? fixed_len : 1 + (p * 3 + k) % 4;
  endfunction

  function automatic bit srcs_done();
    bit d;
    d = 1'b1;
    for (int p = 0; p < N; p++) if (src_pkt[p] < src_goal[p]) d = 1'b0;
    return d;
  endfunction

  task automatic do_reset();
    axis_reset    = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    @(posedge axis_clk);
    @(posedge axis_clk);
    #1;
    axis_reset = 1'b0;
    for (int p = 0; p < N; p++) begin
      src_goal[p] = 0; src_pkt[p] = 0; src_beat[p] = 0;
      exp_pkt[p]  = 0; exp_beat[p] = 0;
    end
    open_port = -1;
    cyc       = 0;
    fixed_len = 0;
    src_rand  = 1'b0;
    rdy_pct   = 100;
    first_port.delete();
    first_cyc.delete();
  endtask

  task automatic drive_srcs();
    for (int p = 0; p < N; p++) begin
      if (src_pkt[p] >= src_goal[p]) s_axis_tvalid[p] = 1'b0;
      else if (!s_axis_tvalid[p]) s_axis_tvalid[p] = src_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_tdata[p*DW +: DW] = mk(p, src_pkt[p], src_beat[p]);
      s_axis_tlast[p]          = (src_beat[p] == plen(p, src_pkt[p]) - 1);
    end
    m_axis_tready = ($urandom_range(1, 100) <= rdy_pct);
  endtask

  task automatic sb_beat();
    int p;
    p = int'(m_axis_tdata[27:24]);
    chk("port_range", p < N, 1);
    if (p >= N) p = 0;
    if (open_port < 0) begin
      open_port = p;
      first_port.push_back(p);
      first_cyc.push_back(cyc);
    end
    chk("no_interleave", p, open_port);
    chk("grant_id_match", grant_id, p);
    chk("beat_data", m_axis_tdata, mk(p, exp_pkt[p], exp_beat[p]));
    chk("beat_last", m_axis_tlast, exp_beat[p] == plen(p, exp_pkt[p]) - 1);
    if (exp_beat[p] == plen(p, exp_pkt[p]) - 1) begin
      exp_beat[p] = 0;
      exp_pkt[p]++;
      open_port = -1;
    end else begin
      exp_beat[p]++;
    end
  endtask

  task automatic auto_cycle();
    logic [N-1:0] hs;
    smp();
    hs = s_axis_tvalid & s_axis_tready;
    chk("one_hs", $countones(hs), (m_axis_tvalid && m_axis_tready) ? 1 : 0);
    if (m_axis_tvalid && m_axis_tready) sb_beat();
    nxt();
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        s_axis_tvalid[p] = 1'b0;
        if (src_beat[p] == plen(p, src_pkt[p]) - 1) begin
          src_beat[p] = 0;
          src_pkt[p]++;
        end else begin
          src_beat[p]++;
        end
      end
    end
    drive_srcs();
  endtask

  task automatic run_auto(input int budget);
    int k;
    k = 0;
    drive_srcs();
    while ((!srcs_done() || open_port >= 0) && k < budget) begin
      auto_cycle();
      k++;
    end
    chk("auto_budget", k < budget, 1);
    for (int p = 0; p < N; p++) chk("pkts_rcvd", exp_pkt[p], src_goal[p]);
  endtask

  initial begin
    // Reset state, with requests present to show nothing leaks through
    axis_reset    = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tlast  = '0;
    s_axis_tdata  = '1;
    m_axis_tready = 1'b1;
    #2 axis_reset = 1'b1;
    repeat (3) @(posedge axis_clk);
    smp();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_s_tready", s_axis_tready, 0);

    // 3-beat packet on port 2
    do_reset();
    set_port(2, 1'b1, 32'hA0, 1'b0);
    smp();
    chk("t1_idle_gv", grant_valid, 0);
    chk("t1_idle_mvld", m_axis_tvalid, 0);
    chk("t1_idle_srdy", s_axis_tready, 0);
    nxt(); smp();
    chk("t1_gv", grant_valid, 1);
    chk("t1_gid", grant_id, 2);
    chk("t1_d0", m_axis_tdata, 32'hA0);
    chk("t1_srdy", s_axis_tready, 4'b0100);
    chk("t1_last0", m_axis_tlast, 0);
    nxt(); set_port(2, 1'b1, 32'hA1, 1'b0); smp();
    chk("t1_d1", m_axis_tdata, 32'hA1);
    nxt(); set_port(2, 1'b1, 32'hA2, 1'b1); smp();
    chk("t1_d2", m_axis_tdata, 32'hA2);
    chk("t1_last2", m_axis_tlast, 1);
    nxt(); set_port(2, 1'b0, 32'h0, 1'b0); smp();
    chk("t1_end_gv", grant_valid, 0);
    chk("t1_end_mvld", m_axis_tvalid, 0);

    // All ports streaming 2-beat packets
    do_reset();
    fixed_len = 2;
    for (int p = 0; p < N; p++) src_goal[p] = 2;
    run_auto(200);
    chk("t2_npkts", first_port.size() >= 5, 1);
    if (first_port.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t2_order", first_port[i], exp_order[i]);
      for (int i = 1; i < 5; i++) chk("t2_gap", first_cyc[i] - first_cyc[i-1], 3);
    end

    // Backpressure mid-packet on port 1 while port 3 requests
    do_reset();
    set_port(1, 1'b1, 32'hB0, 1'b0);
    nxt(); smp();
    chk("t3_gid", grant_id, 1);
    chk("t3_d0", m_axis_tdata, 32'hB0);
    nxt();
    set_port(1, 1'b1, 32'hB1, 1'b0);
    set_port(3, 1'b1, 32'hC0, 1'b1);
    m_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t3_hold_gid", grant_id, 1);
      chk("t3_hold_gv", grant_valid, 1);
      chk("t3_hold_srdy", s_axis_tready, 0);
      chk("t3_hold_data", m_axis_tdata, 32'hB1);
      nxt();
    end
    m_axis_tready = 1'b1;
    smp();
    chk("t3_resume_srdy", s_axis_tready, 4'b0010);
    chk("t3_d1", m_axis_tdata, 32'hB1);
    nxt(); set_port(1, 1'b1, 32'hB2, 1'b1); smp();
    chk("t3_d2", m_axis_tdata, 32'hB2);
    chk("t3_d2_srdy", s_axis_tready, 4'b0010);
    nxt(); set_port(1, 1'b0, 32'h0, 1'b0); smp();
    chk("t3_bubble_gv", grant_valid, 0);
    nxt(); smp();
    chk("t3_next_gid", grant_id, 3);
    chk("t3_next_data", m_axis_tdata, 32'hC0);
    chk("t3_next_srdy", s_axis_tready, 4'b1000);
    nxt(); set_port(3, 1'b0, 32'h0, 1'b0); smp();
    chk("t3_end_gv", grant_valid, 0);

    // Single-beat packets, ports 0 and 3 together after last_grant=0
    do_reset();
    set_port(0, 1'b1, 32'hD0, 1'b1);
    nxt(); smp();
    chk("t4_first_gid", grant_id, 0);
    nxt();
    set_port(0, 1'b1, 32'hD1, 1'b1);
    set_port(3, 1'b1, 32'hD3, 1'b1);
    smp();
    chk("t4_idle_gv", grant_valid, 0);
    nxt(); smp();
    chk("t4_gid3", grant_id, 3);
    chk("t4_data3", m_axis_tdata, 32'hD3);
    nxt(); set_port(3, 1'b0, 32'h0, 1'b0); smp();
    chk("t4_bubble_gv", grant_valid, 0);
    nxt(); smp();
    chk("t4_gid0", grant_id, 0);
    chk("t4_data0", m_axis_tdata, 32'hD1);
    nxt(); set_port(0, 1'b0, 32'h0, 1'b0);

    // Reset mid-packet on port 2
    do_reset();
    set_port(2, 1'b1, 32'hE0, 1'b0);
    nxt(); smp();
    chk("t5_gid", grant_id, 2);
    nxt();
    axis_reset = 1'b1;
    smp();
    chk("t5_rst_mvld", m_axis_tvalid, 0);
    chk("t5_rst_srdy", s_axis_tready, 0);
    chk("t5_rst_gv", grant_valid, 0);
    set_port(2, 1'b0, 32'h0, 1'b0);
    nxt();
    axis_reset = 1'b0;
    set_port(1, 1'b1, 32'hF1, 1'b1);
    set_port(2, 1'b1, 32'hF2, 1'b1);
    smp();
    chk("t5_idle_gv", grant_valid, 0);
    nxt(); smp();
    chk("t5_gid1", grant_id, 1);
    chk("t5_data1", m_axis_tdata, 32'hF1);
    nxt(); set_port(1, 1'b0, 32'h0, 1'b0);
    nxt(); smp();
    chk("t5_gid2", grant_id, 2);
    nxt(); set_port(2, 1'b0, 32'h0, 1'b0);

    // Random valid/ready stress with scoreboard
    do_reset();
    src_goal = '{6, 5, 7, 4};
    src_rand = 1'b1;
    rdy_pct  = 70;
    run_auto(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
